// File: rtl/register_spill_unit.sv
// Context save/restore engine: walks register_bank R0..R(NUM_REGS-1) and spills them to,
// or reloads them from, data memory one register at a time over a req/ack handshake.
module register_spill_unit #(
  parameter int NUM_REGS   = 8,
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_save_start,
  input  logic                  in_restore_start,
  input  logic [ADDR_WIDTH-1:0] in_base_addr,
  output logic                  out_busy,
  output logic                  out_done,
  output logic                  out_bank_read_en,
  output logic                  out_bank_write_en,
  output logic [2:0]            out_bank_rx_selector,
  output logic [2:0]            out_bank_ry_selector,
  output logic                  out_bank_indirect_mode_en,
  output logic [DATA_WIDTH-1:0] out_bank_data,
  input  logic [DATA_WIDTH-1:0] in_bank_bus_data,
  output logic                  out_mem_req,
  output logic                  out_mem_we,
  output logic [ADDR_WIDTH-1:0] out_mem_addr,
  output logic [DATA_WIDTH-1:0] out_mem_wdata,
  input  logic                  in_mem_ack,
  input  logic [DATA_WIDTH-1:0] in_mem_rdata
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SV_RD  = 3'd1,
    SV_CAP = 3'd2,
    SV_MEM = 3'd3,
    RS_MEM = 3'd4,
    RS_WR  = 3'd5,
    DONE   = 3'd6
  } state_t;

  localparam logic [2:0] LAST_IDX = 3'(NUM_REGS - 1);

  state_t                state, state_nxt;
  logic [2:0]            idx;
  logic [DATA_WIDTH-1:0] hold;
  logic [ADDR_WIDTH-1:0] base;

  // Last driven values, presented on the memory/bank data pins between strobes.
  logic [ADDR_WIDTH-1:0] mem_addr_q;
  logic                  mem_we_q;
  logic [DATA_WIDTH-1:0] mem_wdata_q;
  logic [DATA_WIDTH-1:0] bank_data_q;

  logic                  read_en, write_en, req, we_live, done;
  logic                  start_acc, last;
  logic [ADDR_WIDTH-1:0] addr_live;

  function automatic logic [ADDR_WIDTH-1:0] slot_addr(input logic [ADDR_WIDTH-1:0] b,
                                                      input logic [2:0]            i);
    return b + ADDR_WIDTH'(i);
  endfunction

  assign start_acc = (state == IDLE) && (in_save_start || in_restore_start);
  assign last      = (idx == LAST_IDX);
  assign addr_live = slot_addr(base, idx);

  always_comb begin
    state_nxt = state;
    read_en   = 1'b0;
    write_en  = 1'b0;
    req       = 1'b0;
    we_live   = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (in_save_start)         state_nxt = SV_RD;
        else if (in_restore_start) state_nxt = RS_MEM;
      end
      SV_RD: begin
        read_en   = 1'b1;
        state_nxt = SV_CAP;
      end
      SV_CAP: begin
        read_en   = 1'b1;
        state_nxt = SV_MEM;
      end
      SV_MEM: begin
        req     = 1'b1;
        we_live = 1'b1;
        if (in_mem_ack) state_nxt = last ? DONE : SV_RD;
      end
      RS_MEM: begin
        req = 1'b1;
        if (in_mem_ack) state_nxt = RS_WR;
      end
      RS_WR: begin
        write_en  = 1'b1;
        state_nxt = last ? DONE : RS_MEM;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx         <= '0;
      hold        <= '0;
      base        <= '0;
      mem_addr_q  <= '0;
      mem_we_q    <= 1'b0;
      mem_wdata_q <= '0;
      bank_data_q <= '0;
    end else begin
      if (start_acc) begin
        idx  <= '0;
        base <= in_base_addr;
      end
      if (state == SV_CAP) hold <= in_bank_bus_data;
      if (state == RS_MEM && in_mem_ack) hold <= in_mem_rdata;
      if ((state == SV_MEM && in_mem_ack && !last) || (state == RS_WR && !last))
        idx <= idx + 3'd1;
      if (req) begin
        mem_addr_q <= addr_live;
        mem_we_q   <= we_live;
        if (we_live) mem_wdata_q <= hold;
      end
      if (write_en) bank_data_q <= hold;
    end
  end

  assign out_busy                  = (state != IDLE);
  assign out_done                  = done;
  assign out_bank_read_en          = read_en;
  assign out_bank_write_en         = write_en;
  assign out_bank_ry_selector      = read_en  ? idx : 3'd0;
  assign out_bank_rx_selector      = write_en ? idx : 3'd0;
  assign out_bank_indirect_mode_en = 1'b0;
  assign out_bank_data             = write_en ? hold : bank_data_q;
  assign out_mem_req               = req;
  assign out_mem_we                = req ? we_live : mem_we_q;
  assign out_mem_addr              = req ? addr_live : mem_addr_q;
  assign out_mem_wdata             = (req && we_live) ? hold : mem_wdata_q;

endmodule

// File: tb/tb_register_spill_unit.sv
// Directed bench for register_spill_unit with a behavioural bank and a wait-state memory.
module tb_register_spill_unit;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       save_start, restore_start;
  logic [7:0] base_addr;
  logic       busy, done, rd_en, wr_en, ind_en, mem_req, mem_we, mem_ack;
  logic [2:0] rx_sel, ry_sel;
  logic [7:0] bank_data, bank_bus, mem_addr, mem_wdata, mem_rdata;

  register_spill_unit #(.NUM_REGS(8), .DATA_WIDTH(8), .ADDR_WIDTH(8)) dut (
    .clk                      (clk),
    .rst_n                    (rst_n),
    .in_save_start            (save_start),
    .in_restore_start         (restore_start),
    .in_base_addr             (base_addr),
    .out_busy                 (busy),
    .out_done                 (done),
    .out_bank_read_en         (rd_en),
    .out_bank_write_en        (wr_en),
    .out_bank_rx_selector     (rx_sel),
    .out_bank_ry_selector     (ry_sel),
    .out_bank_indirect_mode_en(ind_en),
    .out_bank_data            (bank_data),
    .in_bank_bus_data         (bank_bus),
    .out_mem_req              (mem_req),
    .out_mem_we               (mem_we),
    .out_mem_addr             (mem_addr),
    .out_mem_wdata            (mem_wdata),
    .in_mem_ack               (mem_ack),
    .in_mem_rdata             (mem_rdata)
  );

  always #5 clk = ~clk;

  // Bank model: preload array plus DUT-written array with valid bits.
  logic [7:0] bank_pre [8];
  logic [7:0] bank_wr  [8];
  logic [7:0] bank_wv = '0;
  assign bank_bus = bank_wv[ry_sel] ? bank_wr[ry_sel] : bank_pre[ry_sel];
  always @(posedge clk)
    if (wr_en) begin
      bank_wr[rx_sel] <= bank_data;
      bank_wv[rx_sel] <= 1'b1;
    end

  // Memory model: reads from a preloaded image, writes into a separate image.
  logic [7:0] mem_rd [256];
  logic [7:0] mem_wr [256];
  int         mem_waits = 0;
  int         wcnt = 0;
  int         log_cnt = 0;
  int         done_cnt = 0;
  int         both_en_cnt = 0;
  int         ind_cnt = 0;
  logic [7:0] addr_log [64];
  logic       we_log   [64];
  assign mem_ack   = mem_req && (wcnt >= mem_waits);
  assign mem_rdata = mem_rd[mem_addr];
  always @(posedge clk) begin
    if (mem_req && !mem_ack) wcnt <= wcnt + 1;
    else                     wcnt <= 0;
    if (mem_req && mem_ack) begin
      if (mem_we) mem_wr[mem_addr] <= mem_wdata;
      addr_log[log_cnt % 64] <= mem_addr;
      we_log[log_cnt % 64]   <= mem_we;
      log_cnt <= log_cnt + 1;
    end
    if (done) done_cnt <= done_cnt + 1;
  end
  always @(negedge clk) begin
    if (rd_en && wr_en) both_en_cnt <= both_en_cnt + 1;
    if (ind_en)         ind_cnt     <= ind_cnt + 1;
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] all_outs();
    return {27'd0, busy, done, rd_en, wr_en, rx_sel, ry_sel, ind_en, bank_data,
            mem_req, mem_we, mem_addr, mem_wdata};
  endfunction

  // Pulses start at a negedge; edge E is the next posedge. Returns the cycle (1-based
  // after E) in which done was seen, busy in cycle 1 and busy in the cycle after done.
  task automatic run_seq(input bit sv, input bit rs, input logic [7:0] b, input int inject,
                         output int done_cyc, output logic busy1, output logic busy_after);
    int n;
    @(negedge clk);
    save_start    = sv;
    restore_start = rs;
    base_addr     = b;
    @(posedge clk);
    n        = 0;
    done_cyc = -1;
    busy1    = 1'b0;
    while (n < 400) begin
      @(negedge clk);
      n++;
      if (n == 1) begin
        save_start    = 1'b0;
        restore_start = 1'b0;
        busy1         = busy;
      end
      if (inject != 0 && n == inject)     restore_start = 1'b1;
      if (inject != 0 && n == inject + 1) restore_start = 1'b0;
      if (done) begin
        done_cyc = n;
        break;
      end
    end
    restore_start = 1'b0;
    @(negedge clk);
    busy_after = busy;
  endtask

  initial begin
    int   dc, lb, dcnt0, bound;
    logic b1, ba;
    logic we_ok;

    for (int i = 0; i < 256; i++) mem_rd[i] = 8'h00;
    for (int i = 0; i < 8; i++) begin
      mem_rd[8'h40 + i] = 8'hA0 + 8'(i);
      bank_pre[i]       = 8'h10 + 8'(i);
    end
    rst_n = 1'b0;
    save_start = 1'b0;
    restore_start = 1'b0;
    base_addr = 8'h00;
    repeat (3) @(negedge clk);
    chk("reset_outputs", all_outs(), 64'd0);
    chk("reset_busy", {63'd0, busy}, 64'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Save, zero wait states
    mem_waits = 0;
    lb = log_cnt;
    run_seq(1'b1, 1'b0, 8'h20, 0, dc, b1, ba);
    chk("save_done_cycle", 64'(dc), 64'd25);
    chk("save_busy_c1", {63'd0, b1}, 64'd1);
    chk("save_busy_c26", {63'd0, ba}, 64'd0);
    for (int i = 0; i < 8; i++)
      chk($sformatf("save_mem%0d", i), {56'd0, mem_wr[8'h20 + i]}, 64'h10 + 64'(i));
    we_ok = 1'b1;
    for (int i = 0; i < 8; i++) if (we_log[(lb + i) % 64] !== 1'b1) we_ok = 1'b0;
    chk("save_we", {63'd0, we_ok}, 64'd1);

    // Restore, two wait states per access
    mem_waits = 2;
    lb = log_cnt;
    run_seq(1'b0, 1'b1, 8'h40, 0, dc, b1, ba);
    chk("restore_done_cycle", 64'(dc), 64'd33);
    for (int i = 0; i < 8; i++)
      chk($sformatf("restore_bank%0d", i), {56'd0, bank_wr[i]}, 64'hA0 + 64'(i));
    we_ok = 1'b1;
    for (int i = 0; i < 8; i++) if (we_log[(lb + i) % 64] !== 1'b0) we_ok = 1'b0;
    chk("restore_we", {63'd0, we_ok}, 64'd1);
    chk("restore_indirect", 64'(ind_cnt), 64'd0);

    // Address wrap: bank now holds A0..A7
    mem_waits = 0;
    lb = log_cnt;
    run_seq(1'b1, 1'b0, 8'hFC, 0, dc, b1, ba);
    chk("wrap_done_cycle", 64'(dc), 64'd25);
    for (int i = 0; i < 8; i++)
      chk($sformatf("wrap_addr%0d", i), {56'd0, addr_log[(lb + i) % 64]}, 64'(8'(8'hFC + i)));
    chk("wrap_mem_00", {56'd0, mem_wr[8'h00]}, 64'hA4);
    chk("wrap_mem_03", {56'd0, mem_wr[8'h03]}, 64'hA7);

    // Both starts together, then restore pulsed while busy
    lb = log_cnt;
    dcnt0 = done_cnt;
    run_seq(1'b1, 1'b1, 8'h80, 5, dc, b1, ba);
    chk("arb_done_cycle", 64'(dc), 64'd25);
    we_ok = 1'b1;
    for (int i = 0; i < 8; i++) if (we_log[(lb + i) % 64] !== 1'b1) we_ok = 1'b0;
    chk("arb_we", {63'd0, we_ok}, 64'd1);
    chk("arb_mem_87", {56'd0, mem_wr[8'h87]}, 64'hA7);
    repeat (30) @(negedge clk);
    chk("arb_single_done", 64'(done_cnt - dcnt0), 64'd1);
    chk("arb_idle_after", {63'd0, busy}, 64'd0);
    chk("arb_ops", 64'(log_cnt - lb), 64'd8);

    // Reset in the middle of a save
    lb = log_cnt;
    dcnt0 = done_cnt;
    @(negedge clk);
    save_start = 1'b1;
    base_addr  = 8'h90;
    @(negedge clk);
    save_start = 1'b0;
    bound = 0;
    while (log_cnt - lb < 3 && bound < 200) begin
      @(negedge clk);
      bound++;
    end
    chk("midrst_progress", 64'(log_cnt - lb), 64'd3);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_outputs", all_outs(), 64'd0);
    chk("midrst_busy", {63'd0, busy}, 64'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("midrst_no_done", 64'(done_cnt - dcnt0), 64'd0);
    chk("midrst_ops", 64'(log_cnt - lb), 64'd3);
    run_seq(1'b1, 1'b0, 8'hB0, 0, dc, b1, ba);
    chk("post_rst_done_cycle", 64'(dc), 64'd25);
    for (int i = 0; i < 8; i++)
      chk($sformatf("post_rst_mem%0d", i), {56'd0, mem_wr[8'hB0 + i]}, 64'hA0 + 64'(i));

    chk("rd_wr_exclusive", 64'(both_en_cnt), 64'd0);
    chk("indirect_zero", 64'(ind_cnt), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/register_spill_unit.md
# register_spill_unit

Context save/restore engine for the 8-entry `register_bank`. It is the initiator on the bank's port set: it drives `read_en`/`write_en`, the selectors and `in_data`, and consumes `out_bus_data`. On command it walks all registers and either spills them to a data memory (save) or reloads them from it (restore), one register at a time over a req/ack memory handshake. It sits beside the control unit and is used for interrupt entry/exit and task switches.

## Interface
Parameters:
- `NUM_REGS`, default 8: registers walked (R0..R`NUM_REGS`-1).
- `DATA_WIDTH`, default 8: register/memory data width.
- `ADDR_WIDTH`, default 8: memory address width.

Ports:
- `clk`  in  1  single clock, all state changes on rising edge.
- `rst_n`  in  1  reset; asynchronous and active-low.
- `in_save_start`  in  1  one-cycle save command, sampled in IDLE only.
- `in_restore_start`  in  1  one-cycle restore command, sampled in IDLE only.
- `in_base_addr`  in  ADDR_WIDTH  memory address of R0's slot, latched at start.
- `out_busy`  out  1  high from the cycle after an accepted start through the DONE cycle.
- `out_done`  out  1  one-cycle pulse at completion.
- `out_bank_read_en`  out  1  to bank `read_en`.
- `out_bank_write_en`  out  1  to bank `write_en`.
- `out_bank_rx_selector`  out  3  to bank `in_rx_selector` (write target).
- `out_bank_ry_selector`  out  3  to bank `in_ry_selector` (read source).
- `out_bank_indirect_mode_en`  out  1  to bank; constant 0.
- `out_bank_data`  out  DATA_WIDTH  to bank `in_data`.
- `in_bank_bus_data`  in  DATA_WIDTH  from bank `out_bus_data`.
- `out_mem_req`  out  1  memory request, held until ack.
- `out_mem_we`  out  1  1 = write, 0 = read; valid with req.
- `out_mem_addr`  out  ADDR_WIDTH  `base + index`, modulo 2^ADDR_WIDTH.
- `out_mem_wdata`  out  DATA_WIDTH  write data; valid with req and we.
- `in_mem_ack`  in  1  completes the current request in the cycle it is high with req.
- `in_mem_rdata`  in  DATA_WIDTH  read data, valid in the ack cycle.

## Operation
- States: IDLE, SV_RD, SV_CAP, SV_MEM, RS_MEM, RS_WR, DONE. Index counter `idx` (3 bits), data holding register `hold`, latched `base`.
- IDLE: on `in_save_start` → SV_RD; else on `in_restore_start` → RS_MEM; idx←0, base←`in_base_addr`. Both high: save wins; restore is dropped.
- SV_RD: read_en=1, ry_selector=idx. → SV_CAP.
- SV_CAP: read_en=1, ry_selector=idx; hold←`in_bank_bus_data` at end of cycle. → SV_MEM. (Two-cycle read covers both combinational and registered bank bus output.)
- SV_MEM: req=1, we=1, addr=base+idx, wdata=hold. On ack: idx==NUM_REGS-1 → DONE, else idx++ → SV_RD.
- RS_MEM: req=1, we=0, addr=base+idx. On ack: hold←`in_mem_rdata` → RS_WR.
- RS_WR: write_en=1, rx_selector=idx, bank data=hold. Last idx → DONE, else idx++ → RS_MEM.
- DONE: done=1, busy=1 → IDLE.
- Invariants: read_en and write_en never both high; req never high outside SV_MEM/RS_MEM; mem outputs and bank data keep last value when not strobed, selectors 0 in IDLE.
- Starts while busy are ignored (no queueing).

## Timing
- Reset (async assert, any state): state IDLE, idx=0, hold=0, base=0; every output 0; no done pulse for an aborted sequence. Deassertion is synchronised by the integrator.
- Start accepted at edge E; busy high from cycle after E.
- Save: per register 2 + W cycles, W = cycles req is high (W≥1, ack may come in first req cycle). Zero-wait total: 24 cycles + DONE = done in 25th cycle after E.
- Restore: per register W + 1 cycles. Zero-wait total: 16 + DONE = done in 17th cycle after E.
- Address wrap: base+idx truncated to ADDR_WIDTH (0xFE+3 = 0x01).
- Bank write of register idx takes effect at the end of its RS_WR cycle.
- Ack while req low is ignored.

## Test plan
- Reset: assert `rst_n`=0 mid-cycle → all outputs 0 immediately, busy=0.
- Save, zero-wait: bank R0..R7 = 0x10..0x17, base 0x20, ack tied to req → mem[0x20..0x27] = 0x10..0x17, done in cycle 25, busy low in cycle 26.
- Restore, 2 wait states per access: mem[0x40..0x47] = 0xA0..0xA7, base 0x40 → bank R0..R7 = 0xA0..0xA7, done in cycle 33 (8×4+1); indirect_mode_en stays 0.
- Wrap: save with base 0xFC → addresses FC,FD,FE,FF,00,01,02,03 in order.
- Arbitration: save and restore pulsed together → save sequence (we=1); restore_start pulsed while busy → ignored, single done.
- Reset mid-save after 3 registers: → IDLE, no done, next save from R0 completes normally.
